shifter_fifo_ctrl: RTL and testbench

- Controller that turns the 2-D shift-register datapath (shifter_2d, instantiated alongside it) into a synchronous FIFO.
- Owns occupancy, full/empty status, error flags and the shifter's enable, modo, seleccion and clear controls.
- Pushes shift data into tap 0. The oldest word always sits at tap count-1 and is read through the variable-tap output.
- Sits between a producer/consumer pair and one shifter_2d instance of matching parameters.

---
 rtl/shifter_fifo_pkg.sv | 25 ++
 rtl/shifter_fifo_ctrl.sv | 132 +++++++++++++
 tb/tb_shifter_fifo_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/shifter_fifo_pkg.sv
// Shared definitions for the shifter-based FIFO controller: state codes and
// width helpers derived from the FIFO depth.
package shifter_fifo_pkg;

  typedef logic [1:0] fifo_state_t;

  localparam fifo_state_t ST_EMPTY   = 2'd0;
  localparam fifo_state_t ST_PARTIAL = 2'd1;
  localparam fifo_state_t ST_FULL    = 2'd2;
  localparam fifo_state_t ST_FLUSH   = 2'd3;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Tap-select width of the shifter's variable output.
  function automatic int sel_width(input int depth);
    return $clog2(depth - 1);
  endfunction

  localparam int CNT_W = cnt_width(32);
  localparam int SEL_W = sel_width(32);

endpackage

// File: rtl/shifter_fifo_ctrl.sv
// FIFO controller wrapped around a shifter_2d datapath. New words shift in at
// tap 0; the oldest word lives at tap count-1 and is read via the variable tap.
module shifter_fifo_ctrl
  import shifter_fifo_pkg::*;
#(
  parameter int tamanyo = 32,
  parameter int size    = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               push,
  input  logic [size-1:0]                    data_in,
  input  logic                               pop,
  output logic [size-1:0]                    data_out,
  output logic                               data_valid,
  output logic                               fifo_full,
  output logic                               fifo_empty,
  output logic [cnt_width(tamanyo)-1:0]      count,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               sh_enable,
  output logic                               sh_modo,
  output logic [sel_width(tamanyo)-1:0]      sh_seleccion,
  output logic [size-1:0]                    sh_entrada,
  output logic                               sh_clear,
  input  logic [size-1:0]                    sh_salida
);

  localparam int CW = cnt_width(tamanyo);
  localparam int SW = sel_width(tamanyo);
  localparam logic [CW-1:0] DEPTH = CW'(tamanyo);
  localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE   = CW'(1);

  fifo_state_t     state;
  fifo_state_t     state_next;
  logic [CW-1:0]   count_next;
  logic            flushing;
  logic            push_ok;
  logic            pop_ok;

  // A flush request on the input, or the flush cycle itself, swallows
  // any push/pop presented in the same cycle.
  assign flushing   = (state == ST_FLUSH) || !clear;

  // Status comes only from the registered occupancy.
  assign fifo_full  = (count == DEPTH);
  assign fifo_empty = (count == ZERO);

  // Push is allowed when full only if a pop frees the oldest slot at the
  // same edge (the shift discards exactly the word being read).
  assign push_ok    = push & (!fifo_full | pop) & !flushing;
  assign pop_ok     = pop & !fifo_empty & !flushing;

  assign sh_enable    = push_ok;
  assign sh_modo      = 1'b1;
  assign sh_entrada   = data_in;
  assign sh_clear     = (state != ST_FLUSH);
  assign sh_seleccion = fifo_empty ? {SW{1'b0}} : SW'(count - ONE);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + ONE;
      2'b01:   count_next = count - ONE;
      default: count_next = count;
    endcase
  end

  // Next state: flush request dominates, otherwise follow the new occupancy.
  always_comb begin
    state_next = state;
    if (!clear) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: state_next = ST_EMPTY;
        ST_EMPTY, ST_PARTIAL, ST_FULL: begin
          if (count_next == ZERO) begin
            state_next = ST_EMPTY;
          end else if (count_next == DEPTH) begin
            state_next = ST_FULL;
          end else begin
            state_next = ST_PARTIAL;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State, occupancy and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      count     <= ZERO;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_next;
      if (flushing) begin
        count     <= ZERO;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        count <= count_next;
        if (push && !push_ok) begin
          overflow <= 1'b1;
        end
        if (pop && !pop_ok) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  // Read port: capture the pre-shift oldest word and pulse data_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out   <= {size{1'b0}};
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (pop_ok) begin
        data_out <= sh_salida;
      end
    end
  end

endmodule

// File: tb/tb_shifter_fifo_ctrl.sv
// Bench for shifter_fifo_ctrl: a behavioural shift register stands in for
// shifter_2d, and a queue-based FIFO model supplies every expected value.
module tb_shifter_fifo_ctrl;

  localparam int DEPTH = 32;
  localparam int W     = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         clear;
  logic         push;
  logic [W-1:0] data_in;
  logic         pop;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         fifo_full;
  logic         fifo_empty;
  logic [5:0]   count;
  logic         overflow;
  logic         underflow;
  logic         sh_enable;
  logic         sh_modo;
  logic [4:0]   sh_seleccion;
  logic [W-1:0] sh_entrada;
  logic         sh_clear;
  logic [W-1:0] sh_salida;

  int vectors = 0;
  int errors  = 0;

  // Reference FIFO state.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ovf;
  logic         m_udf;
  logic         m_flush;

  always #5 clock = ~clock;

  shifter_fifo_ctrl #(.tamanyo(DEPTH), .size(W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .push(push),
    .data_in(data_in), .pop(pop), .data_out(data_out),
    .data_valid(data_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .sh_enable(sh_enable), .sh_modo(sh_modo), .sh_seleccion(sh_seleccion),
    .sh_entrada(sh_entrada), .sh_clear(sh_clear), .sh_salida(sh_salida)
  );

  // Behavioural shifter_2d: shift into tap 0, variable-tap read, active-low clear.
  logic [W-1:0] taps [DEPTH];
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (!sh_clear) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (sh_enable) begin
      for (int i = DEPTH - 1; i > 0; i--) taps[i] <= taps[i-1];
      taps[0] <= sh_entrada;
    end
  end
  assign sh_salida = taps[sh_seleccion];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count",      32'(count),      32'(q.size()));
    check("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
    check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("data_out",   32'(data_out),   32'(m_dout));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("underflow",  32'(underflow),  32'(m_udf));
    check("sh_clear",   32'(sh_clear),   32'(!m_flush));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_flush = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check acceptance, then check state after the edge.
  task automatic step(input logic p, input logic o, input logic c, input logic [W-1:0] d);
    logic wok, rok;
    @(negedge clock);
    push = p; pop = o; clear = c; data_in = d;
    #1;
    rok = c && !m_flush && o && (q.size() > 0);
    wok = c && !m_flush && p && ((q.size() < DEPTH) || o);
    check("sh_enable",  32'(sh_enable),  32'(wok));
    check("sh_entrada", 32'(sh_entrada), 32'(d));
    check("sh_modo",    32'(sh_modo),    32'd1);
    @(posedge clock);
    #1;
    if (!c) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_flush = 1'b1;
    end else if (m_flush) begin
      m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_flush = 1'b0;
    end else begin
      m_valid = rok;
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      if (p && !wok) m_ovf = 1'b1;
      if (o && !rok) m_udf = 1'b1;
    end
    check_all();
  endtask

  initial begin
    reset = 1'b0; clear = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b1;

    // Five pushes then five pops.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b1, W'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Fill to full, refused 33rd push, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, W'(i));
    step(1'b1, 1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 8'h00);

    // Clear flags, refill, simultaneous push/pop while full, drain.
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, W'(i));
    step(1'b1, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 8'h00);

    // Push+pop on empty: no fall-through.
    step(1'b1, 1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b1, 1'b1, 8'h00);

    // Flush with simultaneous requests, then normal use again.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, W'(8'h40 + i));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    step(1'b1, 1'b1, 1'b1, 8'hEF);
    step(1'b1, 1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 1'b1, 8'h00);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 40) != 0), 8'($urandom));
    end

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, W'(8'h90 + i));
    step(1'b0, 1'b1, 1'b1, 8'h00);
    @(negedge clock);
    push = 1'b0; pop = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
